// File: rtl/ws2812b_rx.sv
// WS2812B one-wire receiver: classifies high pulses by width into bits,
// assembles MSB-first 24-bit GRB words and flags latch gaps and errors.
module ws2812b_rx #(
    parameter int T1_MIN   = 12,
    parameter int HIGH_MAX = 40,
    parameter int T_RESET  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        data_valid,
    output logic        frame_done,
    output logic        err,
    output logic [7:0]  pixel_cnt
);

    localparam int CMAX = (T_RESET > HIGH_MAX + 1) ? T_RESET : HIGH_MAX + 1;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TR_C  = CW'(T_RESET);
    localparam logic [CW-1:0] HM_C  = CW'(HIGH_MAX);
    localparam logic [CW-1:0] T1_C  = CW'(T1_MIN);
    localparam logic [CW-1:0] CM_C  = CW'(CMAX);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t state, state_n;

    logic s1, s2, s3;
    logic rise, fall;

    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [4:0]    bit_cnt, bit_cnt_n;
    logic [23:0]   shreg, shreg_n, shifted;
    logic [23:0]   data_n;
    logic [7:0]    pix_n;
    logic          valid_n, frame_n, err_n;
    logic          bit_val;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    assign cnt_inc = (cnt == CM_C) ? cnt : cnt + ONE_C;
    assign bit_val = (cnt >= T1_C);
    assign shifted = {shreg[22:0], bit_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= SYNC;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            pixel_cnt  <= '0;
        end else begin
            s1         <= din;
            s2         <= s1;
            s3         <= s2;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            data_out   <= data_n;
            data_valid <= valid_n;
            frame_done <= frame_n;
            err        <= err_n;
            pixel_cnt  <= pix_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        data_n    = data_out;
        pix_n     = pixel_cnt;
        valid_n   = 1'b0;
        frame_n   = 1'b0;
        err_n     = 1'b0;

        unique case (state)
            SYNC: begin
                // Wait for one full quiet gap before trusting any edge.
                if (s2) begin
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TR_C) begin
                        state_n = IDLE;
                    end
                end
            end

            IDLE: begin
                if (rise) begin
                    cnt_n   = ONE_C;
                    state_n = HIGH;
                end else if (cnt < TR_C) begin
                    cnt_n = cnt_inc;
                end
            end

            LOW: begin
                if (rise) begin
                    cnt_n   = ONE_C;
                    state_n = HIGH;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TR_C) begin
                        if (bit_cnt != 5'd0) begin
                            err_n = 1'b1;
                        end else if (pixel_cnt != 8'd0) begin
                            frame_n = 1'b1;
                        end
                        bit_cnt_n = '0;
                        pix_n     = '0;
                        state_n   = IDLE;
                    end
                end
            end

            HIGH: begin
                if (cnt > HM_C) begin
                    err_n     = 1'b1;
                    bit_cnt_n = '0;
                    pix_n     = '0;
                    shreg_n   = '0;
                    cnt_n     = '0;
                    state_n   = SYNC;
                end else if (fall) begin
                    shreg_n = shifted;
                    cnt_n   = ONE_C;
                    state_n = LOW;
                    if (bit_cnt == 5'd23) begin
                        data_n    = shifted;
                        valid_n   = 1'b1;
                        bit_cnt_n = '0;
                        if (pixel_cnt != 8'hFF) begin
                            pix_n = pixel_cnt + 8'd1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            default: begin
                state_n = SYNC;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Self-checking bench for ws2812b_rx: table-driven words, hand corner cases
// and random frames checked against a pulse-level reference model.
module tb_ws2812b_rx;

    localparam int T1_MIN   = 12;
    localparam int HIGH_MAX = 40;
    localparam int T_RESET  = 1000;

    logic        clk;
    logic        rst;
    logic        din;
    logic [23:0] data_out;
    logic        data_valid;
    logic        frame_done;
    logic        err;
    logic [7:0]  pixel_cnt;

    ws2812b_rx #(
        .T1_MIN  (T1_MIN),
        .HIGH_MAX(HIGH_MAX),
        .T_RESET (T_RESET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_done(frame_done),
        .err       (err),
        .pixel_cnt (pixel_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 word, 1 frame_done, 2 err
    typedef struct {
        int          kind;
        logic [23:0] data;
        logic [7:0]  pix;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [23:0] word;
        int          h0;
        int          l0;
        int          h1;
        int          l1;
        logic [23:0] exp;
    } vec_t;

    ev_t exp_q[$];
    ev_t act_q[$];
    ev_t mon_e;

    int total;
    int bad;
    int cyc;

    int          m_sync;
    int          m_nbits;
    int          m_pix;
    logic [23:0] m_sh;
    logic [23:0] m_last;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (data_valid) begin
            mon_e = '{0, data_out, pixel_cnt, cyc};
            act_q.push_back(mon_e);
        end
        if (frame_done) begin
            mon_e = '{1, data_out, pixel_cnt, cyc};
            act_q.push_back(mon_e);
        end
        if (err) begin
            mon_e = '{2, data_out, pixel_cnt, cyc};
            act_q.push_back(mon_e);
        end
    end

    task automatic model_high(input int h, input int k);
        ev_t e;
        if (m_sync == 0) return;
        if (h > HIGH_MAX) begin
            e = '{2, m_last, 8'd0, -1};
            exp_q.push_back(e);
            m_sync  = 0;
            m_nbits = 0;
            m_pix   = 0;
            return;
        end
        m_sh    = {m_sh[22:0], (h >= T1_MIN)};
        m_nbits = m_nbits + 1;
        if (m_nbits == 24) begin
            m_nbits = 0;
            if (m_pix < 255) m_pix = m_pix + 1;
            m_last = m_sh;
            e = '{0, m_sh, 8'(m_pix), k + 2};
            exp_q.push_back(e);
        end
    endtask

    task automatic model_low(input int l);
        ev_t e;
        if (l >= T_RESET) begin
            if (m_sync != 0) begin
                if (m_nbits != 0) begin
                    e = '{2, m_last, 8'd0, -1};
                    exp_q.push_back(e);
                end else if (m_pix > 0) begin
                    e = '{1, m_last, 8'd0, -1};
                    exp_q.push_back(e);
                end
            end
            m_sync  = 1;
            m_nbits = 0;
            m_pix   = 0;
        end
    endtask

    task automatic pulse(input int h, input int l);
        int k;
        repeat (h) begin
            @(negedge clk);
            din = 1'b1;
        end
        @(negedge clk);
        din = 1'b0;
        k = cyc + 1;
        repeat (l - 1) begin
            @(negedge clk);
            din = 1'b0;
        end
        model_high(h, k);
        model_low(l);
    endtask

    task automatic idle(input int l);
        repeat (l) begin
            @(negedge clk);
            din = 1'b0;
        end
        model_low(l);
    endtask

    task automatic send_word(input logic [23:0] w, input int h0, input int l0,
                             input int h1, input int l1, input int last_lo);
        for (int i = 23; i >= 0; i--) begin
            if (w[i]) pulse(h1, (i == 0) ? last_lo : l1);
            else      pulse(h0, (i == 0) ? last_lo : l0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        m_sync  = 0;
        m_nbits = 0;
        m_pix   = 0;
        m_sh    = '0;
        m_last  = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_events(input string name);
        int n;
        repeat (8) @(negedge clk);
        total = total + 1;
        if (act_q.size() != exp_q.size()) begin
            bad = bad + 1;
            $display("FAIL %s count: got %0d want %0d",
                     name, act_q.size(), exp_q.size());
        end
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            total = total + 1;
            if (act_q[i].kind != exp_q[i].kind ||
                act_q[i].data !== exp_q[i].data ||
                act_q[i].pix !== exp_q[i].pix ||
                (exp_q[i].cyc >= 0 && act_q[i].cyc != exp_q[i].cyc)) begin
                bad = bad + 1;
                $display("FAIL %s ev%0d: got kind=%0d data=%h pix=%0d cyc=%0d want kind=%0d data=%h pix=%0d cyc=%0d",
                         name, i, act_q[i].kind, act_q[i].data, act_q[i].pix,
                         act_q[i].cyc, exp_q[i].kind, exp_q[i].data,
                         exp_q[i].pix, exp_q[i].cyc);
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, " data_out"},   {8'd0, data_out}, 32'd0);
        chk({name, " data_valid"}, {31'd0, data_valid}, 32'd0);
        chk({name, " frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({name, " err"},        {31'd0, err}, 32'd0);
        chk({name, " pixel_cnt"},  {24'd0, pixel_cnt}, 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        int          nw;
        int          inj;
        int          h;
        logic [23:0] w;

        total   = 0;
        bad     = 0;
        cyc     = 0;
        rst     = 1'b1;
        din     = 1'b0;
        m_sync  = 0;
        m_nbits = 0;
        m_pix   = 0;
        m_sh    = '0;
        m_last  = '0;

        tbl[0] = '{24'hA53CF0,  8, 17, 16,  9, 24'hA53CF0};
        tbl[1] = '{24'h555555, 11, 10, 12, 10, 24'h555555};
        tbl[2] = '{24'hFFFFFF, 11,  5, 11,  5, 24'h000000};
        tbl[3] = '{24'h555555, 11, 10, 40, 10, 24'h555555};
        tbl[4] = '{24'h0F0F0F,  1,  3, 12,  3, 24'h0F0F0F};
        tbl[5] = '{24'hC3C3C3,  2,  2, 30,  2, 24'hC3C3C3};

        do_reset();
        chk_zero("reset");
        idle(T_RESET);

        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i].word, tbl[i].h0, tbl[i].l0,
                      tbl[i].h1, tbl[i].l1, T_RESET);
            check_events($sformatf("row%0d", i));
            chk($sformatf("row%0d data_out", i), {8'd0, data_out},
                {8'd0, tbl[i].exp});
        end

        send_word(24'h010203, 8, 17, 16, 9, 9);
        send_word(24'hFFFFFF, 8, 17, 16, 9, 17);
        send_word(24'h000000, 8, 17, 16, 9, T_RESET);
        check_events("three_words");

        pulse(45, 5);
        send_word(24'hABCDEF, 8, 17, 16, 9, 20);
        idle(T_RESET);
        check_events("timeout45");
        pulse(41, T_RESET);
        check_events("timeout41");
        send_word(24'h2468AC, 8, 17, 16, 9, T_RESET);
        check_events("after_timeout");

        for (int i = 0; i < 10; i++) pulse(16, (i == 9) ? T_RESET : 9);
        check_events("partial");
        chk("partial pixel_cnt", {24'd0, pixel_cnt}, 32'd0);

        for (int i = 0; i < 12; i++) pulse(8, 17);
        check_events("pre_rst");
        do_reset();
        chk_zero("mid_rst");
        send_word(24'h777777, 8, 17, 16, 9, 20);
        idle(T_RESET);
        check_events("rst_nogap");
        send_word(24'h13579B, 8, 17, 16, 9, T_RESET);
        check_events("rst_resume");

        for (int f = 0; f < 15; f++) begin
            nw  = int'($urandom_range(1, 3));
            inj = int'($urandom_range(0, 9));
            for (int k = 0; k < nw; k++) begin
                w = 24'($urandom);
                for (int i = 23; i >= 0; i--) begin
                    if (inj == 1 && k == nw - 1 && i < 8) break;
                    if (w[i]) h = int'($urandom_range(12, 40));
                    else      h = int'($urandom_range(1, 11));
                    if (inj == 0 && k == nw - 1 && i == 10)
                        h = int'($urandom_range(41, 50));
                    pulse(h, int'($urandom_range(2, 20)));
                end
            end
            idle(int'($urandom_range(1000, 1030)));
            check_events($sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws2812b_rx.md
# ws2812b_rx

WS2812B one-wire stream decoder: the receiving end of the LED data line our I2C-to-WS2812B design drives. It samples `din`, classifies each high pulse as a 0 or 1 bit by width, and assembles MSB-first 24-bit GRB words. It flags a latch gap (frame end) and malformed traffic. It serves as an on-chip loopback monitor for the transmitter and as a decoder for chained-pixel designs.

## Interface
- `T1_MIN`, 12: minimum high time, in clk cycles, for a 1 bit. Shorter high pulses decode as 0.
- `HIGH_MAX`, 40: a high pulse longer than this many cycles is an error.
- `T_RESET`, 1000: low time, in cycles, that constitutes a latch/reset gap (50 µs at 20 MHz).
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `din`, in, 1: asynchronous WS2812B serial input.
- `data_out`, out, 24: last complete word, G[23:16] R[15:8] B[7:0].
- `data_valid`, out, 1: one-cycle pulse when `data_out` updates.
- `frame_done`, out, 1: one-cycle pulse at a latch gap ending a frame of ≥1 word.
- `err`, out, 1: one-cycle pulse on a protocol violation.
- `pixel_cnt`, out, 8: words received in the current frame; saturates at 255.

## Operation
- `din` passes through a 2-flop synchronizer (`s1`, `s2`) and is then registered once more (`s3`) for edge detection.
  - rise = `s2 & !s3`
  - fall = `!s2 & s3`
- Counters:
  - `cnt` is wide enough for `T_RESET` and saturates at `T_RESET`.
  - `bit_cnt` is 0..23.
  - `shreg` is 24 bits.
- States:
  - SYNC: entered on reset. `cnt` counts consecutive low samples of `s2` and clears when `s2` is high. When `cnt` reaches `T_RESET`, go to IDLE. No `err` or `frame_done` is generated in SYNC.
  - IDLE / LOW: on rise, `cnt` <= 1 and go to HIGH. Otherwise `cnt` increments. When `cnt` reaches `T_RESET` (latch gap):
    - If `bit_cnt` != 0: pulse `err` and discard the partial word.
    - Else if `pixel_cnt` > 0: pulse `frame_done`.
    - In both cases clear `pixel_cnt` and `bit_cnt`, then go to IDLE.
  - HIGH: `cnt` increments each cycle. On fall:
    - Bit = (`cnt` >= `T1_MIN`). Shift `shreg` = {`shreg`[22:0], bit}.
    - `bit_cnt`++ and `cnt` <= 1. Go to LOW.
    - If this was bit 24: `data_out` <= the shifted word, pulse `data_valid`, `bit_cnt` <= 0, `pixel_cnt`++ (saturating).
  - HIGH timeout: if `cnt` exceeds `HIGH_MAX`, pulse `err`, clear `bit_cnt` and `pixel_cnt`, and go to SYNC.
- Low time between bits shorter than `T_RESET` is never an error.
- Reset values: `data_out` = 0, `data_valid` = 0, `frame_done` = 0, `err` = 0, `pixel_cnt` = 0. Synchronizer flops reset to 0. State = SYNC.
- `rst` asserted mid-word discards all progress. The block re-enters SYNC and requires a full `T_RESET` low gap before decoding again.

## Timing
- Let k be the first clk edge that samples `din` at a new level.
  - `s2` reflects that level after edge k+1.
  - Any output caused by that edge (`data_valid`, bit classification) is registered at edge k+2, giving a fixed 2-cycle latency.
- Measured high width in `cnt` equals the number of clk edges sampling `din` high (±1 from sampling).
- `data_valid`, `frame_done` and `err` are each high for exactly one cycle. At most one of `frame_done`/`err` fires per latch gap.
- `data_out` holds its value until the next complete word. It is unchanged by `frame_done`, `err` or SYNC; only `rst` clears it.
- `pixel_cnt` updates in the same cycle as `data_valid`. It reads 0 in the cycle after `frame_done`.

## Test plan
- Reset, 1000 low cycles, then word 0xA53CF0 (0 = 8 high/17 low, 1 = 16 high/9 low), then 1000 low -> exactly one `data_valid`, 2 cycles after the 24th falling edge. `data_out` = 0xA53CF0 and `pixel_cnt` = 1. One `frame_done`, after which `pixel_cnt` = 0.
- Three words 0x010203, 0xFFFFFF, 0x000000 back-to-back, then 1000 low -> three `data_valid` pulses with matching `data_out`, `pixel_cnt` 1/2/3, and one `frame_done`.
- Threshold boundary: 24 pulses alternating 11 and 12 high cycles -> `data_out` = 0x555555. Same pattern with `T1_MIN` = 12 and HIGH_MAX pulses of 40 -> no `err`.
- After a gap, a 45-cycle high pulse -> `err` pulse and no `data_valid`. A valid word sent immediately afterwards, with no gap, is ignored. After 1000 low cycles the next word decodes.
- 10 valid bits then 1000 low -> `err` pulse, no `frame_done`, no `data_valid`, `pixel_cnt` = 0.
- Reset then immediate bits with no gap -> ignored. `rst` asserted at bit 12 of a word -> all outputs 0, and decoding resumes only after a 1000-cycle low gap.
